sync_fifo_param: RTL

Parametrised single-clock FIFO, the next generation of the team's 8-bit/16-deep synchronous FIFO. Data width, depth and almost-full/almost-empty thresholds are generic. It adds an occupancy count, sticky overflow/underflow error flags and an optional first-word-fall-through read mode. It sits between any same-clock producer and consumer in the datapath.

---
 rtl/sync_fifo_param_if.sv | 31 +++
 rtl/sync_fifo_param.sv | 99 +++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// Write/read/status bundle for sync_fifo_param: master is the producer/consumer side, slave is the FIFO.
// Widths follow DATA_W and DEPTH; count is $clog2(DEPTH)+1 bits to hold 0..DEPTH.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky overflow/underflow.
// Latency: 1-cycle registered read; FIFO_FWFT_EN selects first-word-fall-through (0-cycle) read.
// Backpressure: writes dropped while full, reads ignored while empty; both flagged as sticky errors.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    sync_fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              ovf_q;
    logic              unf_q;
    logic              full_w;
    logic              empty_w;
    logic              wr_acc;
    logic              rd_acc;

    // Gating looks only at pre-edge occupancy, so a read never makes room for a same-cycle write.
    assign full_w  = (count_q == FULL_C);
    assign empty_w = (count_q == '0);
    assign wr_acc  = bus.wr_en && !full_w;
    assign rd_acc  = bus.rd_en && !empty_w;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A fresh error in the same cycle as clr_err must not be lost.
            if (bus.wr_en && full_w) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (bus.rd_en && empty_w) begin
                unf_q <= 1'b1;
            end else if (bus.clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.dout = empty_w ? '0 : mem[rd_ptr];
`else
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr];
        end
    end

    assign bus.dout = dout_q;
`endif

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
